scr1_tb_imem_cmd_monitor: RTL and testbench

- Parametrised testbench-side instruction-fetch monitor attached to the IMEM response interface of the SCR1 core.
- Compares every valid fetch beat against NCH programmable value/mask patterns and keeps per-channel saturating hit counters.
- Detects an ordered multi-instruction sequence across consecutive valid beats and counts IMEM error responses.
- Instantiated in scr1_top_tb_ahb / scr1_top_tb_axi next to the IMEM router; passive, never drives the bus.

---
 rtl/scr1_tb_cmd_mon_pkg.sv | 17 +
 rtl/scr1_tb_cmd_matcher.sv | 55 +++++
 rtl/scr1_tb_imem_cmd_monitor.sv | 217 +++++++++++++++++++++
 tb/tb_scr1_tb_imem_cmd_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_tb_cmd_mon_pkg.sv
// Shared definitions for the IMEM command monitor: response codes, sequence
// FSM state type and default counter width.
package scr1_tb_cmd_mon_pkg;

  localparam logic [1:0] IMEM_RESP_IDLE = 2'b00;
  localparam logic [1:0] IMEM_RESP_OK   = 2'b01;
  localparam logic [1:0] IMEM_RESP_ERR  = 2'b10;

  localparam int unsigned CMD_MON_CNT_W = 16;

  typedef enum logic [1:0] {
    SeqIdle,
    SeqRun,
    SeqDone
  } type_seq_state_e;

endpackage

// File: rtl/scr1_tb_cmd_matcher.sv
// One pattern channel of the IMEM command monitor: masked compare of the fetch
// data, registered one-cycle hit pulse and a saturating hit counter.
module scr1_tb_cmd_matcher
  import scr1_tb_cmd_mon_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = CMD_MON_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              clear,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] mask,
  output logic              match,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_cnt
);

  logic             hit_d;
  logic             hit_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Mask bits set to 0 are don't-care; an all-zero mask matches any valid beat.
  assign match = valid & (((rdata ^ value) & mask) == '0);

  always_comb begin
    hit_d = 1'b0;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (match) begin
      hit_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hit_q <= hit_d;
      cnt_q <= cnt_d;
    end
  end

  assign hit     = hit_q;
  assign hit_cnt = cnt_q;

endmodule

// File: rtl/scr1_tb_imem_cmd_monitor.sv
// Passive IMEM fetch monitor: NCH masked pattern channels, ordered sequence
// detector over ch0..SEQ_LEN-1 and an error-response counter.
// Define SCR1_TB_CMD_LOG_EN to print hit, sequence and saturation messages.
module scr1_tb_imem_cmd_monitor
  import scr1_tb_cmd_mon_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = CMD_MON_CNT_W,
  parameter int unsigned SEQ_LEN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [1:0]            imem_resp,
  input  logic [DATA_W-1:0]     imem_rdata,
  input  logic [NCH*DATA_W-1:0] pat_value,
  input  logic [NCH*DATA_W-1:0] pat_mask,
  input  logic                  seq_en,
  output logic [NCH-1:0]        hit,
  output logic [NCH*CNT_W-1:0]  hit_cnt,
  output logic                  seq_hit,
  output logic [CNT_W-1:0]      seq_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int unsigned IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN + 1) : 1;

  logic             valid_beat;
  logic             err_beat;
  logic [NCH-1:0]   match;
  logic             run_match;
  logic             seq_complete;

  type_seq_state_e  state_d;
  type_seq_state_e  state_q;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] seq_cnt_d;
  logic [CNT_W-1:0] seq_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;

  assign valid_beat = enable & (imem_resp == IMEM_RESP_OK);
  assign err_beat   = enable & (imem_resp == IMEM_RESP_ERR);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    scr1_tb_cmd_matcher #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_matcher (
      .clk     (clk),
      .rst     (rst),
      .valid   (valid_beat),
      .clear   (clear),
      .rdata   (imem_rdata),
      .value   (pat_value[i*DATA_W +: DATA_W]),
      .mask    (pat_mask[i*DATA_W +: DATA_W]),
      .match   (match[i]),
      .hit     (hit[i]),
      .hit_cnt (hit_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Match of the channel the sequence is currently waiting for.
  always_comb begin
    run_match = 1'b0;
    for (int unsigned i = 0; i < SEQ_LEN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        run_match = match[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seq_complete = 1'b0;
    if (clear || !seq_en) begin
      state_d = SeqIdle;
      idx_d   = '0;
    end else if (!enable) begin
      // Progress is frozen, but the completion pulse must stay one cycle wide.
      if (state_q == SeqDone) begin
        state_d = SeqIdle;
      end
    end else begin
      unique case (state_q)
        SeqIdle, SeqDone: begin
          state_d = SeqIdle;
          idx_d   = '0;
          if (valid_beat && match[0]) begin
            if (SEQ_LEN == 1) begin
              state_d      = SeqDone;
              seq_complete = 1'b1;
            end else begin
              state_d = SeqRun;
              idx_d   = IDX_W'(1);
            end
          end
        end
        SeqRun: begin
          if (err_beat) begin
            state_d = SeqIdle;
            idx_d   = '0;
          end else if (valid_beat) begin
            if (run_match) begin
              if (idx_q == IDX_W'(SEQ_LEN - 1)) begin
                state_d      = SeqDone;
                idx_d        = '0;
                seq_complete = 1'b1;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end else if (match[0]) begin
              idx_d = IDX_W'(1);
            end else begin
              state_d = SeqIdle;
              idx_d   = '0;
            end
          end
        end
        default: begin
          state_d = SeqIdle;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    seq_cnt_d = seq_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      seq_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (seq_complete && (seq_cnt_q != '1)) begin
        seq_cnt_d = seq_cnt_q + CNT_W'(1);
      end
      if (err_beat && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SeqIdle;
      idx_q     <= '0;
      seq_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_cnt_q <= seq_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign seq_hit = (state_q == SeqDone);
  assign seq_cnt = seq_cnt_q;
  assign err_cnt = err_cnt_q;

`ifdef SCR1_TB_CMD_LOG_EN
  logic [DATA_W-1:0] rdata_q;
  logic [NCH+1:0]    sat_logged;

  always_ff @(posedge clk) begin
    rdata_q <= imem_rdata;
  end

  // Report on the falling edge so registered outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      sat_logged = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (hit[i]) begin
          $display("IMEM cmd ch%0d match 0x%08h @%0t", i, rdata_q, $time);
        end
        if (hit_cnt[i*CNT_W +: CNT_W] == '1) begin
          if (!sat_logged[i]) begin
            $display("IMEM cmd ch%0d hit counter saturated @%0t", i, $time);
          end
          sat_logged[i] = 1'b1;
        end else begin
          sat_logged[i] = 1'b0;
        end
      end
      if (seq_hit) begin
        $display("IMEM cmd sequence detected, count %0d", seq_cnt);
      end
      if (seq_cnt == '1) begin
        if (!sat_logged[NCH]) begin
          $display("IMEM cmd sequence counter saturated @%0t", $time);
        end
        sat_logged[NCH] = 1'b1;
      end else begin
        sat_logged[NCH] = 1'b0;
      end
      if (err_cnt == '1) begin
        if (!sat_logged[NCH+1]) begin
          $display("IMEM cmd error counter saturated @%0t", $time);
        end
        sat_logged[NCH+1] = 1'b1;
      end else begin
        sat_logged[NCH+1] = 1'b0;
      end
    end
  end
`else
  // Logging disabled: the monitor produces no simulation output.
`endif

endmodule

// File: tb/tb_scr1_tb_imem_cmd_monitor.sv
// Self-checking bench for scr1_tb_imem_cmd_monitor: a per-cycle reference
// model plus directed vectors with hand-computed expectations.
module tb_scr1_tb_imem_cmd_monitor;

  localparam int unsigned NCH     = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SEQ_LEN = 2;
  localparam int          MAXC    = (1 << CNT_W) - 1;

  localparam logic [31:0] W_CH0 = 32'h057E4505;
  localparam logic [31:0] W_CH1 = 32'h00000013;

  logic                  clk;
  logic                  rst;
  logic                  enable;
  logic                  clear;
  logic [1:0]            imem_resp;
  logic [DATA_W-1:0]     imem_rdata;
  logic [NCH*DATA_W-1:0] pat_value;
  logic [NCH*DATA_W-1:0] pat_mask;
  logic                  seq_en;
  logic [NCH-1:0]        hit;
  logic [NCH*CNT_W-1:0]  hit_cnt;
  logic                  seq_hit;
  logic [CNT_W-1:0]      seq_cnt;
  logic [CNT_W-1:0]      err_cnt;

  int total = 0;
  int bad   = 0;

  scr1_tb_imem_cmd_monitor #(
    .NCH     (NCH),
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W),
    .SEQ_LEN (SEQ_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .imem_resp  (imem_resp),
    .imem_rdata (imem_rdata),
    .pat_value  (pat_value),
    .pat_mask   (pat_mask),
    .seq_en     (seq_en),
    .hit        (hit),
    .hit_cnt    (hit_cnt),
    .seq_hit    (seq_hit),
    .seq_cnt    (seq_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts as plain integers, sequence as "steps matched so far".
  int             m_cnt[NCH];
  int             m_err;
  int             m_seq;
  int             m_prog;
  logic [NCH-1:0] m_hit;
  logic           m_seq_hit;

  function automatic int sat_inc(input int c);
    return (c >= MAXC) ? MAXC : c + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    m_err = 0; m_seq = 0; m_prog = 0; m_hit = '0; m_seq_hit = 1'b0;
  endtask

  task automatic model_step();
    logic           vb;
    logic           eb;
    logic [NCH-1:0] m;
    vb = enable && (imem_resp == 2'b01);
    eb = enable && (imem_resp == 2'b10);
    for (int i = 0; i < NCH; i++) begin
      m[i] = vb && (((imem_rdata ^ pat_value[i*DATA_W +: DATA_W])
                     & pat_mask[i*DATA_W +: DATA_W]) == 0);
    end
    m_seq_hit = 1'b0;
    if (clear) begin
      model_reset();
    end else begin
      m_hit = m;
      for (int i = 0; i < NCH; i++) if (m[i]) m_cnt[i] = sat_inc(m_cnt[i]);
      if (eb) m_err = sat_inc(m_err);
      if (!seq_en) begin
        m_prog = 0;
      end else if (enable) begin
        if (eb) begin
          m_prog = 0;
        end else if (vb) begin
          if (m[m_prog]) m_prog = m_prog + 1;
          else m_prog = m[0] ? 1 : 0;
          if (m_prog == SEQ_LEN) begin
            m_seq_hit = 1'b1;
            m_seq     = sat_inc(m_seq);
            m_prog    = 0;
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      check("hit", 32'(hit), 32'(m_hit));
      for (int i = 0; i < NCH; i++) begin
        check($sformatf("hit_cnt%0d", i), 32'(hit_cnt[i*CNT_W +: CNT_W]), m_cnt[i]);
      end
      check("seq_hit", 32'(seq_hit), 32'(m_seq_hit));
      check("seq_cnt", 32'(seq_cnt), m_seq);
      check("err_cnt", 32'(err_cnt), m_err);
    end
  end

  task automatic beat(input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    imem_resp  = r;
    imem_rdata = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) beat(2'b00, 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    clear      = 1'b0;
    seq_en     = 1'b0;
    imem_resp  = 2'b00;
    imem_rdata = '0;
    // ch0 exact, ch1 low-7-bit opcode, ch2 exact zero, ch3 mask 0 (any beat)
    pat_value  = {32'h0, 32'h0, 32'h00000013, W_CH0};
    pat_mask   = {32'h0, 32'hFFFFFFFF, 32'h0000007F, 32'hFFFFFFFF};

    repeat (2) @(posedge clk);
    #2;
    check("rst_hit", 32'(hit), 0);
    check("rst_hit_cnt", 32'(hit_cnt), 0);
    check("rst_seq", 32'({seq_hit, seq_cnt, err_cnt}), 0);
    @(negedge clk);
    rst = 1'b0;

    beat(2'b01, W_CH0);
    check("ch0_hit", 32'(hit), 32'b1001);
    check("ch0_cnt", 32'(hit_cnt[3:0]), 1);
    beat(2'b01, 32'h057E4506);
    check("ch0_nohit", 32'(hit), 32'b1000);
    check("ch0_cnt_hold", 32'(hit_cnt[3:0]), 1);

    beat(2'b01, 32'h00000013);
    beat(2'b01, 32'h12345693);
    check("ch1_cnt", 32'(hit_cnt[7:4]), 2);
    beat(2'b10, 32'h00000013);
    beat(2'b10, 32'h12345693);
    check("ch1_cnt_err", 32'(hit_cnt[7:4]), 2);
    check("err_cnt2", 32'(err_cnt), 2);
    check("err_nohit", 32'(hit), 0);

    enable = 1'b0;
    beat(2'b01, W_CH0);
    check("dis_hit", 32'(hit), 0);
    check("dis_cnt", 32'(hit_cnt[3:0]), 1);
    check("ch3_cnt", 32'(hit_cnt[15:12]), 4);
    enable = 1'b1;

    pat_mask[63:32] = 32'hFFFFFFFF;
    seq_en          = 1'b1;
    beat(2'b01, W_CH0);
    idle(3);
    beat(2'b01, W_CH1);
    check("seq1_hit", 32'(seq_hit), 1);
    check("seq1_cnt", 32'(seq_cnt), 1);
    idle(1);
    check("seq1_pulse", 32'(seq_hit), 0);

    beat(2'b01, W_CH0);
    beat(2'b01, 32'hDEADBEEF);
    beat(2'b01, W_CH1);
    check("seq_break_hit", 32'(seq_hit), 0);
    check("seq_break_cnt", 32'(seq_cnt), 1);

    beat(2'b01, W_CH0);
    beat(2'b01, W_CH0);
    beat(2'b01, W_CH1);
    check("seq_restart_hit", 32'(seq_hit), 1);
    check("seq_restart_cnt", 32'(seq_cnt), 2);

    beat(2'b01, W_CH0);
    beat(2'b10, 32'h0);
    beat(2'b01, W_CH1);
    check("seq_err_hit", 32'(seq_hit), 0);
    check("seq_err_cnt", 32'(seq_cnt), 2);
    check("err_cnt3", 32'(err_cnt), 3);

    repeat (16) beat(2'b10, 32'h0);
    check("err_sat", 32'(err_cnt), 15);
    repeat (20) beat(2'b01, W_CH0);
    check("ch0_sat", 32'(hit_cnt[3:0]), 15);

    clear = 1'b1;
    beat(2'b01, W_CH0);
    clear = 1'b0;
    check("clr_hit_cnt", 32'(hit_cnt), 0);
    check("clr_hit", 32'(hit), 0);
    check("clr_other", 32'({seq_cnt, err_cnt}), 0);

    beat(2'b01, W_CH0);
    check("pre_rst_cnt", 32'(hit_cnt[3:0]), 1);
    @(negedge clk);
    imem_resp = 2'b00;
    rst       = 1'b1;
    #1;
    check("arst_hit", 32'(hit), 0);
    check("arst_hit_cnt", 32'(hit_cnt), 0);
    check("arst_seq", 32'({seq_hit, seq_cnt, err_cnt}), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    beat(2'b01, W_CH1);
    check("post_rst_seq", 32'(seq_hit), 0);
    check("post_rst_hit", 32'(hit), 32'b1010);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
